// File: rtl/instr_fetch_assembler.sv
// Multicycle instruction fetch: owns the PC, pulls INSTR_BYTES beats over a
// req/ack memory port into a shadow register and publishes the word atomically.
module instr_fetch_assembler #(
    parameter int DATA_W      = 8,
    parameter int INSTR_BYTES = 4,
    parameter int PC_W        = 8,
    parameter int RESET_PC    = 0,
    parameter int BIG_ENDIAN  = 0,
    parameter int TIMEOUT     = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          pc_load,
    input  logic [PC_W-1:0]               pc_in,
    output logic                          mem_rd,
    output logic [PC_W-1:0]               mem_adr,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             memdata,
    output logic [DATA_W*INSTR_BYTES-1:0] instr,
    output logic                          instr_valid,
    output logic                          busy,
    output logic [PC_W-1:0]               pcvalue,
    output logic                          fetch_err
);

    localparam int IW = DATA_W * INSTR_BYTES;
    localparam int BW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [BW-1:0]   LAST   = BW'(INSTR_BYTES - 1);
    localparam logic [WW-1:0]   WLAST  = WW'(TIMEOUT - 1);

    typedef enum logic {IDLE, FETCH} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   adr_q, adr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [IW-1:0]     shadow_q, shadow_d;
    logic [IW-1:0]     instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [BW-1:0]     slot;
    logic [IW-1:0]     merged;

    // Shadow with the current beat already inserted, so the final beat
    // can be published on the same edge it is consumed.
    always_comb begin
        slot   = (BIG_ENDIAN != 0) ? LAST - beat_q : beat_q;
        merged = shadow_q;
        merged[int'(slot)*DATA_W +: DATA_W] = memdata;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        adr_d    = adr_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        shadow_d = shadow_q;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_in;
                end else if (start) begin
                    state_d = FETCH;
                    adr_d   = pc_q;
                    beat_d  = '0;
                    wait_d  = '0;
                end
            end
            FETCH: begin
                if (pc_load) begin
                    pc_d    = pc_in;
                    state_d = IDLE;
                end else if (mem_ack) begin
                    shadow_d = merged;
                    adr_d    = adr_q + PC_W'(1);
                    wait_d   = '0;
                    if (beat_q == LAST) begin
                        instr_d = merged;
                        valid_d = 1'b1;
                        pc_d    = adr_q + PC_W'(1);
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end else if (wait_q == WLAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= PC_RST;
            adr_q    <= PC_RST;
            beat_q   <= '0;
            wait_q   <= '0;
            shadow_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            adr_q    <= adr_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            shadow_q <= shadow_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign mem_rd      = (state_q == FETCH);
    assign busy        = (state_q == FETCH);
    assign mem_adr     = adr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pcvalue     = pc_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Bench for instr_fetch_assembler: little- and big-endian instances share one
// memory model; fetches are checked against words computed from memory bytes.
module tb_instr_fetch_assembler;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset, start, pc_load, mem_ack;
    logic [7:0]  pc_in, memdata;
    logic        mem_rd, instr_valid, busy, fetch_err;
    logic        mem_rd_b, instr_valid_b, busy_b, fetch_err_b;
    logic [7:0]  mem_adr, pcvalue, mem_adr_b, pcvalue_b;
    logic [31:0] instr, instr_b;

    logic [7:0]  mem [256];
    logic [7:0]  m_pc;
    logic [31:0] m_instr, m_instr_b;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    assign memdata = mem[mem_adr];

    instr_fetch_assembler #(.BIG_ENDIAN(0), .TIMEOUT(TMO)) dut_le (
        .clk(clk), .reset(reset), .start(start), .pc_load(pc_load),
        .pc_in(pc_in), .mem_rd(mem_rd), .mem_adr(mem_adr),
        .mem_ack(mem_ack), .memdata(memdata), .instr(instr),
        .instr_valid(instr_valid), .busy(busy), .pcvalue(pcvalue),
        .fetch_err(fetch_err)
    );

    instr_fetch_assembler #(.BIG_ENDIAN(1), .TIMEOUT(TMO)) dut_be (
        .clk(clk), .reset(reset), .start(start), .pc_load(pc_load),
        .pc_in(pc_in), .mem_rd(mem_rd_b), .mem_adr(mem_adr_b),
        .mem_ack(mem_ack), .memdata(memdata), .instr(instr_b),
        .instr_valid(instr_valid_b), .busy(busy_b), .pcvalue(pcvalue_b),
        .fetch_err(fetch_err_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Instruction word as the memory bytes at pc..pc+3 define it.
    function automatic logic [31:0] ref_word(input logic [7:0] pc,
                                             input bit be);
        logic [31:0] w;
        logic [7:0]  a;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            a = pc + 8'(k);
            if (be) w = w | (32'(mem[a]) << (8 * (3 - k)));
            else    w = w | (32'(mem[a]) << (8 * k));
        end
        return w;
    endfunction

    task automatic set_pc(input logic [7:0] p, input bit with_start);
        pc_load = 1'b1;
        pc_in   = p;
        start   = with_start;
        @(negedge clk);
        pc_load = 1'b0;
        start   = 1'b0;
        chk("pc_load_val", 64'(pcvalue), 64'(p));
        chk("pc_load_idle", 64'(busy), 64'(0));
        m_pc = p;
    endtask

    // fixw >= 0: that many wait cycles per beat, else random 0..maxw.
    // acks < 4: timeout on beat 'acks'. abort_beat in 0..3: pc_load there.
    task automatic fetch(input int fixw, input int maxw, input int acks,
                         input int abort_beat, input logic [7:0] abort_pc);
        logic [7:0] base;
        logic [7:0] a;
        int         w;
        base  = m_pc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("valid_pulse", 64'(instr_valid), 64'(0));
        for (int b = 0; b < 4; b++) begin
            a = base + 8'(b);
            if (b == abort_beat) begin
                pc_load = 1'b1;
                pc_in   = abort_pc;
                mem_ack = 1'b1;
                chk("abort_adr", 64'(mem_adr), 64'(a));
                @(negedge clk);
                pc_load = 1'b0;
                mem_ack = 1'b0;
                chk("abort_rd", 64'(mem_rd), 64'(0));
                chk("abort_valid", 64'(instr_valid), 64'(0));
                chk("abort_pc", 64'(pcvalue), 64'(abort_pc));
                chk("abort_instr", 64'(instr), 64'(m_instr));
                chk("abort_instr_be", 64'(instr_b), 64'(m_instr_b));
                m_pc = abort_pc;
                return;
            end
            if (b >= acks) begin
                mem_ack = 1'b0;
                for (int i = 0; i < TMO; i++) begin
                    chk("tmo_adr", 64'(mem_adr), 64'(a));
                    chk("tmo_rd", 64'(mem_rd), 64'(1));
                    chk("tmo_err_early", 64'(fetch_err), 64'(0));
                    @(negedge clk);
                end
                chk("tmo_err", 64'(fetch_err), 64'(1));
                chk("tmo_busy", 64'(busy), 64'(0));
                chk("tmo_pc", 64'(pcvalue), 64'(base));
                chk("tmo_instr", 64'(instr), 64'(m_instr));
                chk("tmo_valid", 64'(instr_valid), 64'(0));
                @(negedge clk);
                chk("tmo_err_pulse", 64'(fetch_err), 64'(0));
                return;
            end
            w = (fixw >= 0) ? fixw : int'($urandom_range(0, maxw));
            for (int i = 0; i < w; i++) begin
                mem_ack = 1'b0;
                chk("wait_adr", 64'(mem_adr), 64'(a));
                @(negedge clk);
                chk("wait_err", 64'(fetch_err), 64'(0));
                chk("wait_busy", 64'(busy), 64'(1));
            end
            mem_ack = 1'b1;
            chk("beat_adr", 64'(mem_adr), 64'(a));
            chk("beat_rd", 64'(mem_rd), 64'(1));
            @(negedge clk);
            mem_ack = 1'b0;
        end
        m_instr   = ref_word(base, 1'b0);
        m_instr_b = ref_word(base, 1'b1);
        m_pc      = base + 8'd4;
        chk("done_valid", 64'(instr_valid), 64'(1));
        chk("done_instr", 64'(instr), 64'(m_instr));
        chk("done_instr_be", 64'(instr_b), 64'(m_instr_b));
        chk("done_pc", 64'(pcvalue), 64'(m_pc));
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_err", 64'(fetch_err), 64'(0));
    endtask

    initial begin
        int r;
        reset   = 1'b1;
        start   = 1'b0;
        pc_load = 1'b0;
        pc_in   = '0;
        mem_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20;
        mem[1] = 8'h20;
        mem[2] = 8'h85;
        mem[3] = 8'h00;
        #1;
        chk("rst_rd", 64'(mem_rd), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_instr", 64'(instr), 64'(0));
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_err", 64'(fetch_err), 64'(0));
        chk("rst_pc", 64'(pcvalue), 64'(0));
        chk("rst_adr", 64'(mem_adr), 64'(0));
        m_pc = '0;
        m_instr = '0;
        m_instr_b = '0;
        @(negedge clk);
        reset = 1'b0;

        fetch(0, 0, 4, -1, 8'h00);
        chk("le_word", 64'(instr), 64'h0085_2020);
        chk("be_word", 64'(instr_b), 64'h2020_8500);
        chk("le_pc", 64'(pcvalue), 64'h04);
        @(negedge clk);
        chk("valid_drop", 64'(instr_valid), 64'(0));

        set_pc(8'h00, 1'b0);
        fetch(2, 0, 4, -1, 8'h00);
        chk("wait_word", 64'(instr), 64'h0085_2020);

        set_pc(8'h00, 1'b1);
        fetch(0, 0, 4, 2, 8'h40);
        chk("abort_keep", 64'(instr), 64'h0085_2020);
        fetch(0, 1, 4, -1, 8'h00);
        chk("after_abort_pc", 64'(pcvalue), 64'h44);

        set_pc(8'hFE, 1'b0);
        fetch(0, 0, 2, -1, 8'h00);
        chk("wrap_tmo_pc", 64'(pcvalue), 64'hFE);
        fetch(-1, 3, 4, -1, 8'h00);
        chk("wrap_pc", 64'(pcvalue), 64'h02);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rd", 64'(mem_rd), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_instr", 64'(instr), 64'(0));
        chk("mid_rst_instr_be", 64'(instr_b), 64'(0));
        chk("mid_rst_pc", 64'(pcvalue), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        m_pc = '0;
        m_instr = '0;
        m_instr_b = '0;
        fetch(0, 0, 4, -1, 8'h00);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 4) set_pc(8'($urandom), r[0]);
            if (r == 5) fetch(-1, 4, 4, int'($urandom_range(0, 3)), 8'($urandom));
            else if (r == 6) fetch(-1, 2, int'($urandom_range(0, 3)), -1, 8'h00);
            else fetch(-1, 4, 4, -1, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_assembler.md
Name: instr_fetch_assembler

Overview:
- Parametrised fetch unit for the multicycle datapath.
- Fetches an INSTR_BYTES-wide instruction over a DATA_W-wide memory port with a req/ack handshake, assembles it in a shadow register, and publishes it atomically to the instruction register.
- Owns the PC. Replaces the externally sequenced one-hot irwrite byte loading with an internal sequencer.
- Adds wait-state tolerance, selectable byte order, fetch abort, and timeout detection.

Parameters:
DATA_W, 8, memory data width and byte-slot width in bits
INSTR_BYTES, 4, memory beats per instruction (>=1)
PC_W, 8, PC and address width; arithmetic modulo 2^PC_W
RESET_PC, 0, PC value on reset
BIG_ENDIAN, 0, 0: beat k fills instr[DATA_W*k +: DATA_W]; 1: beat k fills slot INSTR_BYTES-1-k
TIMEOUT, 15, max wait cycles for mem_ack per beat before fetch_err (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request one instruction fetch from the current pc
pc_load  in  1  load pc_in into PC; aborts any fetch in progress
pc_in  in  PC_W  new PC value
mem_rd  out  1  memory read request; high in FETCH
mem_adr  out  PC_W  byte address of the current beat
mem_ack  in  1  memdata valid this cycle; beat consumed at the clock edge
memdata  in  DATA_W  memory read data
instr  out  DATA_W*INSTR_BYTES  last completely fetched instruction
instr_valid  out  1  one-cycle pulse; instr updated on the preceding edge
busy  out  1  high in FETCH
pcvalue  out  PC_W  current PC
fetch_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async): state=IDLE, PC=RESET_PC, instr=0, shadow=0, beat count=0, wait count=0, mem_rd=0, mem_adr=RESET_PC, instr_valid=0, fetch_err=0, busy=0.
- States: IDLE and FETCH. mem_rd and busy are decoded combinationally from state. All other outputs are registered.
- IDLE:
  - pc_load=1 sets PC<=pc_in.
  - Otherwise, start=1 enters FETCH with fetch_adr<=PC, beat=0, wait=0.
  - pc_load and start together: pc_load wins. PC loads and the state stays IDLE.
- FETCH: mem_rd=1, mem_adr=fetch_adr.
  - mem_ack=1: write memdata into the slot selected by beat and BIG_ENDIAN; fetch_adr+1 (wraps); wait<=0.
  - Final beat (beat==INSTR_BYTES-1) with ack: instr<=completed shadow, including this beat, on the same edge; instr_valid<=1; PC<=fetch_adr+1; state<=IDLE.
  - Non-final beat with ack: beat+1.
  - mem_ack=0: wait+1. If wait==TIMEOUT-1: fetch_err<=1, state<=IDLE, PC and instr unchanged.
  - pc_load=1: abort. PC<=pc_in, state<=IDLE, instr unchanged, no instr_valid. Any mem_ack in the same cycle is ignored. Abort takes priority over completion and over timeout.
  - start is ignored in FETCH.
- Latency: zero-wait memory with start sampled at edge E0 gives acks consumed at E1..E_INSTR_BYTES. instr_valid is high for the cycle after E_INSTR_BYTES. Back-to-back: start may be high during the instr_valid cycle, and the next fetch begins at that edge.
- instr never shows a partially assembled value. The shadow register holds stale slots between fetches; every slot is overwritten before publish.
- Wrap-around: fetch_adr and PC wrap modulo 2^PC_W; a fetch may straddle the wrap.
- Reset asserted mid-fetch returns to the reset values immediately. mem_rd drops asynchronously.

Test Plan:
- Little-endian, zero-wait: mem bytes 0x20,0x20,0x85,0x00 at 0..3, start at PC=0 -> mem_adr 0,1,2,3 on consecutive cycles; instr=0x00852020; instr_valid pulse; pcvalue=4; busy low after.
- BIG_ENDIAN=1, same bytes -> instr=0x20208500; pcvalue=4.
- Wait states: ack delayed 2 cycles per beat -> mem_adr holds during the waits; instr=0x00852020 after 12 cycles in FETCH; no fetch_err.
- Abort: pc_load=1, pc_in=0x40 after beat 1 -> no instr_valid; instr keeps its prior value; pcvalue=0x40; mem_rd=0 next cycle; a new start fetches from 0x40.
- Timeout and wrap: PC=0xFE, ack only for the first 2 beats -> mem_adr 0xFE, 0xFF, then 0x00 for TIMEOUT cycles; fetch_err pulse; pcvalue stays 0xFE. Rerun with full acks -> pcvalue=0x02.
- Reset mid-fetch after beat 2 -> mem_rd, busy, instr, pcvalue all return to their reset values at once; the next start fetches from RESET_PC.
